// File: rtl/nuc_pkg.sv
// Shared types for the nucleotide loader: 2-bit nucleotide codes, loader
// states and the ASCII-to-nucleotide mapping.
package nuc_pkg;

  typedef enum logic [1:0] {NUC_A, NUC_C, NUC_G, NUC_T} nuc_t;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DONE, ST_ERR} loader_state_t;

  localparam logic [7:0] CHAR_TERM = 8'h2E;

  typedef struct packed {
    logic legal;
    nuc_t nuc;
  } nuc_dec_t;

  // Case-insensitive; anything outside ACGT/acgt comes back with legal=0.
  function automatic nuc_dec_t char_to_nuc(input logic [7:0] c);
    nuc_dec_t d;
    d = '{legal: 1'b1, nuc: NUC_A};
    case (c)
      8'h41, 8'h61: d.nuc = NUC_A;
      8'h43, 8'h63: d.nuc = NUC_C;
      8'h47, 8'h67: d.nuc = NUC_G;
      8'h54, 8'h74: d.nuc = NUC_T;
      default:      d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/Counter.sv
// Library up-counter with synchronous clear taking priority over enable.
module Counter #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_clear,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)        r_count <= '0;
    else if (i_clear) r_count <= '0;
    else if (i_en)    r_count <= r_count + WIDTH'(1);
  end

  assign o_count = r_count;

endmodule

// File: rtl/nuc_char_decode.sv
// Combinational ASCII classifier: nucleotide code, legal-nucleotide flag and
// terminator flag.
module nuc_char_decode
  import nuc_pkg::*;
(
  input  logic [7:0] i_char,
  output logic       o_legal,
  output logic       o_term,
  output nuc_t       o_code
);

  nuc_dec_t w_dec;

  assign w_dec   = char_to_nuc(i_char);
  assign o_legal = w_dec.legal;
  assign o_code  = w_dec.nuc;
  assign o_term  = (i_char == CHAR_TERM);

endmodule

// File: rtl/nuc_loader.sv
// Streaming nucleotide writer: accepts ASCII over valid/ready and issues one
// registered 2-bit write per nucleotide to consecutive addresses from 0.
module nuc_loader
  import nuc_pkg::*;
#(
  parameter int DW = 2,
  parameter int W  = 65536,
  parameter int AW = $clog2(W)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic [7:0]    char_in,
  input  logic          char_valid,
  output logic          char_ready,
  output logic          we,
  output logic [AW-1:0] Addr,
  output logic [DW-1:0] Data,
  output logic [AW:0]   count,
  output logic          busy,
  output logic          done,
  output logic          full,
  output logic          error
);

  localparam logic [AW:0] LAST_CNT = (AW+1)'(W - 1);

  loader_state_t r_state;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_data;
  logic          r_done;
  logic          r_full;
  logic          r_error;

  logic          w_legal;
  logic          w_term;
  nuc_t          w_code;
  logic          w_accept;
  logic          w_nuc_accept;
  logic          w_start_ok;
  logic [AW:0]   w_count;

  nuc_char_decode u_decode (
    .i_char  (char_in),
    .o_legal (w_legal),
    .o_term  (w_term),
    .o_code  (w_code)
  );

  assign w_accept     = char_valid && char_ready;
  assign w_nuc_accept = w_accept && w_legal;
  // start is ignored mid-load, so it only clears the counter outside LOAD.
  assign w_start_ok   = start && (r_state != ST_LOAD);

  Counter #(.WIDTH(AW + 1)) u_count (
    .clock   (clock),
    .reset   (reset),
    .i_clear (w_start_ok),
    .i_en    (w_nuc_accept),
    .o_count (w_count)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_done  <= 1'b0;
      r_full  <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_we <= 1'b0;
      case (r_state)
        ST_LOAD: begin
          if (w_accept) begin
            if (w_term) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else if (w_legal) begin
              r_we   <= 1'b1;
              r_addr <= w_count[AW-1:0];
              r_data <= w_code;
              // The last free word is written and the load closes in the same step.
              if (w_count == LAST_CNT) begin
                r_state <= ST_DONE;
                r_done  <= 1'b1;
                r_full  <= 1'b1;
              end
            end else begin
              r_state <= ST_ERR;
              r_error <= 1'b1;
            end
          end
        end
        default: begin
          if (start) begin
            r_state <= ST_LOAD;
            r_done  <= 1'b0;
            r_full  <= 1'b0;
            r_error <= 1'b0;
          end
        end
      endcase
    end
  end

  assign char_ready = (r_state == ST_LOAD);
  assign busy       = (r_state == ST_LOAD);
  assign we         = r_we;
  assign Addr       = r_addr;
  assign Data       = r_data;
  assign count      = w_count;
  assign done       = r_done;
  assign full       = r_full;
  assign error      = r_error;

endmodule

// File: tb/tb_nuc_loader.sv
// Directed bench for nuc_loader: a full-depth instance for streaming cases and
// a 4-word instance for the memory-full case.
module tb_nuc_loader;

  logic        clock;
  logic        reset;
  logic        start_a;
  logic        start_b;
  logic [7:0]  char_in;
  logic        char_valid;

  logic        ready_a, we_a, busy_a, done_a, full_a, error_a;
  logic [15:0] addr_a;
  logic [1:0]  data_a;
  logic [16:0] count_a;

  logic        ready_b, we_b, busy_b, done_b, full_b, error_b;
  logic [1:0]  addr_b;
  logic [1:0]  data_b;
  logic [2:0]  count_b;

  int n_checks = 0;
  int n_errors = 0;

  nuc_loader u_dut_a (
    .clock      (clock),
    .reset      (reset),
    .start      (start_a),
    .char_in    (char_in),
    .char_valid (char_valid),
    .char_ready (ready_a),
    .we         (we_a),
    .Addr       (addr_a),
    .Data       (data_a),
    .count      (count_a),
    .busy       (busy_a),
    .done       (done_a),
    .full       (full_a),
    .error      (error_a)
  );

  nuc_loader #(.W(4)) u_dut_b (
    .clock      (clock),
    .reset      (reset),
    .start      (start_b),
    .char_in    (char_in),
    .char_valid (char_valid),
    .char_ready (ready_b),
    .we         (we_b),
    .Addr       (addr_b),
    .Data       (data_b),
    .count      (count_b),
    .busy       (busy_b),
    .done       (done_b),
    .full       (full_b),
    .error      (error_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 ns past it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    string      s;
    logic [1:0] exp_code [4];

    reset      = 1'b1;
    start_a    = 1'b0;
    start_b    = 1'b0;
    char_in    = 8'h00;
    char_valid = 1'b0;
    #12;
    check("rst_we",    we_a,    0);
    check("rst_busy",  busy_a,  0);
    check("rst_count", count_a, 0);
    check("rst_flags", {done_a, full_a, error_a, ready_a}, 0);
    check("rst_addr",  {addr_a, data_a}, 0);
    reset = 1'b0;
    step();

    // "ACGT." back-to-back
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    check("t1_busy",  busy_a,  1);
    check("t1_ready", ready_a, 1);
    check("t1_cnt0",  count_a, 0);
    s = "ACGT";
    char_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      char_in = s[i];
      step();
      check("t1_we",   we_a,   1);
      check("t1_addr", addr_a, i);
      check("t1_data", data_a, i);
    end
    char_in = 8'h2E;
    step();
    char_valid = 1'b0;
    check("t1_we_term", we_a,    0);
    check("t1_done",    done_a,  1);
    check("t1_count",   count_a, 4);
    check("t1_error",   error_a, 0);
    check("t1_ready",   ready_a, 0);

    // "gaTc." with two idle cycles between characters
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    check("t2_clr_done", done_a,  0);
    check("t2_clr_cnt",  count_a, 0);
    s = "gaTc";
    exp_code = '{2'b10, 2'b00, 2'b11, 2'b01};
    for (int i = 0; i < 4; i++) begin
      char_valid = 1'b1;
      char_in    = s[i];
      step();
      char_valid = 1'b0;
      check("t2_we",   we_a,   1);
      check("t2_addr", addr_a, i);
      check("t2_data", data_a, exp_code[i]);
      for (int g = 0; g < 2; g++) begin
        step();
        check("t2_gap_we",    we_a,    0);
        check("t2_gap_ready", ready_a, 1);
      end
    end
    char_valid = 1'b1;
    char_in    = 8'h2E;
    step();
    char_valid = 1'b0;
    check("t2_done",  done_a,  1);
    check("t2_count", count_a, 4);

    // "AC" then illegal 'X', then restart with "T."
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    char_valid = 1'b1;
    char_in = "A";
    step();
    char_in = "C";
    step();
    check("t3_we_c",   we_a,   1);
    check("t3_addr_c", addr_a, 1);
    char_in = "X";
    step();
    char_valid = 1'b0;
    check("t3_we_x",  we_a,    0);
    check("t3_error", error_a, 1);
    check("t3_done",  done_a,  0);
    check("t3_count", count_a, 2);
    check("t3_addr",  addr_a,  1);
    check("t3_ready", ready_a, 0);
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    check("t3_clr_err", error_a, 0);
    check("t3_clr_cnt", count_a, 0);
    char_valid = 1'b1;
    char_in = "T";
    step();
    check("t3_we_t",   we_a,   1);
    check("t3_addr_t", addr_a, 0);
    check("t3_data_t", data_a, 3);
    char_in = 8'h2E;
    step();
    char_valid = 1'b0;
    check("t3_done2",  done_a,  1);
    check("t3_count2", count_a, 1);

    // W=4 instance: "AAAAA" fills memory, fifth 'A' not consumed
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    char_valid = 1'b1;
    char_in = "A";
    for (int i = 0; i < 4; i++) begin
      step();
      check("t4_we",   we_b,   1);
      check("t4_addr", addr_b, i);
      check("t4_data", data_b, 0);
    end
    check("t4_full",  full_b,  1);
    check("t4_done",  done_b,  1);
    check("t4_ready", ready_b, 0);
    check("t4_count", count_b, 4);
    step();
    char_valid = 1'b0;
    check("t4_we5",    we_b,    0);
    check("t4_count5", count_b, 4);
    check("t4_busy5",  busy_b,  0);

    // start and char_valid together in DONE: start wins, then '.' gives an empty load
    start_a    = 1'b1;
    char_valid = 1'b1;
    char_in    = "A";
    step();
    start_a = 1'b0;
    check("t6_we_start", we_a,    0);
    check("t6_cnt",      count_a, 0);
    check("t6_busy",     busy_a,  1);
    char_in = 8'h2E;
    step();
    char_valid = 1'b0;
    check("t6_we_term", we_a,    0);
    check("t6_done",    done_a,  1);
    check("t6_count",   count_a, 0);

    // Asynchronous reset while a write strobe is high
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    char_valid = 1'b1;
    char_in = "G";
    step();
    check("t5_we_pre", we_a, 1);
    #2;
    reset = 1'b1;
    #1;
    check("t5_we_rst",    we_a,    0);
    check("t5_busy_rst",  busy_a,  0);
    check("t5_count_rst", count_a, 0);
    #3;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t5_idle_we",   we_a,    0);
      check("t5_idle_busy", busy_a,  0);
      check("t5_idle_cnt",  count_a, 0);
    end
    char_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
